imem_boot_loader: RTL
=====================

# imem_boot_loader

Byte-stream boot loader that fills the core's instruction memory before execution. It accepts a framed byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instructions, and drives the instruction memory write port at consecutive word addresses starting at 0. It holds the core in reset until the whole image has been written and its checksum verified.

## Interface
- MEM_DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, 10, word-address width; MEM_DEPTH ≤ 2^ADDR_W.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte; transfer occurs on the clk edge where rx_valid && rx_ready.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address (PC>>2 equivalent).
- mem_wdata  output  32  instruction word.
- busy  output  1  load in progress (any byte accepted, not yet DONE/ERR).
- done  output  1  image loaded and checksum matched.
- err  output  1  load failed.
- cpu_rst  output  1  active-low reset to the core; 0 until done.

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes, then one checksum byte = XOR of all payload bytes (0x00 when N=0).
- States: LEN_LO → LEN_HI → DATA → CHK → DONE, or → ERR.
- LEN_HI accepted: N > MEM_DEPTH → ERR; N = 0 → CHK; else → DATA.
- DATA: bytes b0..b3 of each word collected; word = {b3,b2,b1,b0}. Running XOR updated on every payload byte. After b3 of word N−1 → CHK.
- CHK: accepted byte equal to running XOR → DONE, else → ERR.
- DONE: done=1, cpu_rst=1, rx_ready=0. ERR: err=1, cpu_rst=0, rx_ready=0. Both terminal until rst.
- rx_ready = rst && state ∈ {LEN_LO, LEN_HI, DATA, CHK}.
- Word index counter: ADDR_W+1 bits, starts at 0, increments after each write; never wraps since N ≤ MEM_DEPTH.
- Bytes presented while rx_ready=0 are ignored (not consumed).

## Timing
- Reset (rst=0 at a clk edge): state=LEN_LO, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst=0, word index=0, XOR=0. rx_ready=0 while rst=0.
- Reset mid-load aborts the frame; memory retains partial contents; next frame restarts at address 0.
- Write latency: mem_we=1 for exactly one cycle, the cycle after b3 is accepted, with mem_addr/mem_wdata valid in that same cycle (registered).
- Back-to-back bytes accepted every cycle; rx_ready does not drop during a write.
- Last word's write and CHK state coincide; checksum byte may be accepted in that same cycle.
- done/err/cpu_rst assert the cycle after the deciding byte (LEN_HI or checksum) is accepted.
- busy asserts the cycle after LEN_LO is accepted; deasserts together with done/err assertion.

## Test plan
- Stream 02 00 13 05 A0 00 93 05 50 00 70, rx_valid continuous → writes addr0=0x00A00513, addr1=0x00500593, one-cycle mem_we each; done=1, cpu_rst=1, err=0.
- Same stream, checksum 0x71 → both writes occur, then err=1, done=0, cpu_rst=0, rx_ready=0; further bytes not consumed.
- 00 00 00 → done=1, no mem_we; 00 00 01 → err=1.
- 01 04 (N=1025, MEM_DEPTH=1024) → err=1 after second byte, no mem_we, rx_ready=0.
- Test 1 stream with random rx_valid gaps → identical writes and result; then rst=0 after 6 bytes of a new frame → all outputs reset values; fresh frame writes from addr 0.
- N=1024 of incrementing words, no gaps → 1024 writes, last at addr 1023 with correct data, done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: unpacks a length-prefixed, XOR-checksummed frame into instruction
// memory words and releases the core from reset once the image is verified.
module imem_boot_loader #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_rst_o
);

    typedef enum logic [2:0] {
        StLenLo,
        StLenHi,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   next_idx;

    assign rx_ready_o = rst && (state_q == StLenLo || state_q == StLenHi ||
                                state_q == StData  || state_q == StChk);
    assign accept     = rx_valid_i && rx_ready_o;
    assign len_full   = {rx_data_i, len_lo_q};
    assign next_idx   = widx_q + 1'b1;

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q == StLenHi) || (state_q == StData) || (state_q == StChk);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StErr);
    assign cpu_rst_o   = (state_q == StDone);

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        widx_d     = widx_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            StLenLo: begin
                if (accept) begin
                    len_lo_d = rx_data_i;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_full;
                    if (32'(len_full) > MEM_DEPTH) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    xor_d      = xor_q ^ rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = rx_data_i;
                        2'd1: word_d[15:8]  = rx_data_i;
                        2'd2: word_d[23:16] = rx_data_i;
                        default: begin
                            // Fourth byte completes the word; the write is registered.
                            we_d    = 1'b1;
                            addr_d  = widx_q[ADDR_W-1:0];
                            wdata_d = {rx_data_i, word_q};
                            widx_d  = next_idx;
                            if (32'(next_idx) == 32'(len_q)) begin
                                state_d = StChk;
                            end
                        end
                    endcase
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (rx_data_i == xor_q) ? StDone : StErr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state_q    <= StLenLo;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            widx_q     <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            widx_q     <= widx_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule
